// File: rtl/wallace_pkg.sv
// Shared widths and scheduler state encoding for the Wallace multiplier scheduler.
package wallace_pkg;

  localparam int OP_W   = 5;
  localparam int PROD_W = 10;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } sched_state_t;

endpackage

// File: rtl/wallace_mul_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               any_req
);

  // Scan upward from ptr modulo NUM_REQ; the first hit wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_req = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      int unsigned idx;
      idx = (k + 32'(ptr)) % NUM_REQ;
      if (!any_req && req[idx]) begin
        any_req  = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/wallace_mul_scheduler.sv
// Time-shares one external 5x5 multiplier between NUM_REQ requesters.
module wallace_mul_scheduler
  import wallace_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MUL_LAT = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*OP_W-1:0] req_a,
  input  logic [NUM_REQ*OP_W-1:0] req_b,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [OP_W-1:0]         mul_a,
  output logic [OP_W-1:0]         mul_b,
  input  logic [PROD_W-1:0]       mul_p,
  output logic                    rsp_valid,
  output logic [PROD_W-1:0]       rsp_data,
  output logic [ID_W-1:0]         rsp_id,
  input  logic                    rsp_ready,
  output logic                    busy
);

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  sched_state_t        state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [OP_W-1:0]     mul_a_q, mul_a_d;
  logic [OP_W-1:0]     mul_b_q, mul_b_d;
  logic [PROD_W-1:0]   rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic                rsp_valid_q, rsp_valid_d;

  logic [NUM_REQ-1:0]  gnt;
  logic [ID_W-1:0]     gnt_idx;
  logic                any_req;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_req (any_req)
  );

  // Next-state, grant and datapath capture logic.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_valid_d = rsp_valid_q;
    req_ready   = '0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          req_ready = gnt;
          mul_a_d   = req_a[int'(gnt_idx)*OP_W +: OP_W];
          mul_b_d   = req_b[int'(gnt_idx)*OP_W +: OP_W];
          rsp_id_d  = gnt_idx;
          rr_ptr_d  = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + ID_W'(1);
          cnt_d     = CNT_W'(MUL_LAT - 1);
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rsp_data_d  = mul_p;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // No handshake may complete while reset is asserted.
    if (rst) req_ready = '0;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_valid = rsp_valid_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_wallace_mul_scheduler.sv
// Scoreboard bench for wallace_mul_scheduler with a one-stage registered multiplier model.
module tb_wallace_mul_scheduler;

  localparam int NUM_REQ = 4;
  localparam int MUL_LAT = 2;
  localparam int ID_W    = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*5-1:0]  req_a, req_b;
  logic [NUM_REQ-1:0]    req_ready;
  logic [4:0]            mul_a, mul_b;
  logic [9:0]            mul_p;
  logic                  rsp_valid;
  logic [9:0]            rsp_data;
  logic [ID_W-1:0]       rsp_id;
  logic                  rsp_ready;
  logic                  busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int rsp_count = 0;
  int last_grant_cyc = 0;
  bit rsp_valid_prev = 1'b0;

  int exp_data_q[$];
  int exp_id_q[$];
  int grant_log[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: one register stage, so early sampling returns a stale product.
  logic [9:0] mul_p_r = '0;
  always @(posedge clk) mul_p_r <= {5'b0, mul_a} * {5'b0, mul_b};
  assign mul_p = mul_p_r;

  wallace_mul_scheduler #(
    .NUM_REQ (NUM_REQ),
    .MUL_LAT (MUL_LAT),
    .ID_W    (ID_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input int a, input int b);
    req_a[i*5 +: 5] = 5'(a);
    req_b[i*5 +: 5] = 5'(b);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_grants(input int n);
    int target;
    target = grant_log.size() + n;
    for (int i = 0; i < 200 && grant_log.size() < target; i++) tick();
    if (grant_log.size() < target) check("grant_timeout", grant_log.size(), target);
  endtask

  task automatic wait_rsp_valid();
    int k;
    k = 0;
    while (!rsp_valid && k < 50) begin tick(); k++; end
    if (!rsp_valid) check("rsp_valid_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_data_q.size() != 0; i++) tick();
    check("drain_empty", exp_data_q.size(), 0);
  endtask

  // Monitor: pushes expectations on grant, pops on response, checks latency and grant shape.
  always @(negedge clk) begin
    if (rst) begin
      exp_data_q.delete();
      exp_id_q.delete();
      rsp_valid_prev = 1'b0;
    end else begin
      if (req_ready != '0) begin
        check("gnt_onehot", int'($onehot(req_ready)), 1);
        check("gnt_valid", int'(req_ready & ~req_valid), 0);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_data_q.push_back(int'(req_a[i*5 +: 5]) * int'(req_b[i*5 +: 5]));
          exp_id_q.push_back(i);
          grant_log.push_back(i);
          last_grant_cyc = cyc;
        end
      end
      if (rsp_valid && !rsp_valid_prev)
        check("latency", cyc - last_grant_cyc, MUL_LAT + 1);
      if (rsp_valid && rsp_ready) begin
        rsp_count++;
        if (exp_data_q.size() == 0) begin
          check("unexpected_rsp", 1, 0);
        end else begin
          check("rsp_data", int'(rsp_data), exp_data_q.pop_front());
          check("rsp_id", int'(rsp_id), exp_id_q.pop_front());
        end
      end
      rsp_valid_prev = rsp_valid;
    end
  end

  initial begin
    int base, cnt0, sd, si, sa, sb, glen;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    req_valid = 4'b1111;
    tick();
    tick();
    // Reset state with requests pending
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_mul_a", int'(mul_a), 0);
    check("rst_mul_b", int'(mul_b), 0);
    check("rst_rsp_data", int'(rsp_data), 0);
    check("rst_rsp_id", int'(rsp_id), 0);
    req_valid = '0;
    rst = 1'b0;
    tick();

    // Single request 31*31
    set_op(0, 31, 31);
    req_valid = 4'b0001;
    #1;
    check("single_ready", int'(req_ready), 1);
    wait_grants(1);
    req_valid = '0;
    cnt0 = rsp_count;
    for (int i = 0; i < 20 && rsp_count == cnt0; i++) tick();
    check("single_done", rsp_count - cnt0, 1);
    check("single_idle", int'(busy), 0);

    // Fairness from rr_ptr=0
    do_reset();
    set_op(0, 3, 5); set_op(1, 7, 9); set_op(2, 31, 1); set_op(3, 0, 17);
    base = grant_log.size();
    req_valid = 4'b1111;
    wait_grants(5);
    req_valid = '0;
    for (int i = 0; i < 5; i++)
      check($sformatf("fair_gnt%0d", i), grant_log[base + i], i % 4);
    drain();

    // Backpressure on requester 2 (16*16), requester 1 pending during RESP
    do_reset();
    set_op(2, 16, 16); set_op(1, 0, 31);
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    wait_grants(1);
    req_valid = '0;
    wait_rsp_valid();
    sd = int'(rsp_data); si = int'(rsp_id); sa = int'(mul_a); sb = int'(mul_b);
    check("bp_data", sd, 256);
    req_valid = 4'b0010;
    glen = grant_log.size();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", int'(rsp_valid), 1);
      check("bp_data_hold", int'(rsp_data), sd);
      check("bp_id_hold", int'(rsp_id), si);
      check("bp_mul_a_hold", int'(mul_a), sa);
      check("bp_mul_b_hold", int'(mul_b), sb);
      check("bp_no_ready", int'(req_ready), 0);
    end
    check("bp_no_grant", grant_log.size(), glen);
    rsp_ready = 1'b1;
    #1;
    check("bp_hs_no_ready", int'(req_ready), 0);
    tick();
    // rr_ptr=3 after serving 2; only requester 1 valid -> skip to 1
    check("wrap_ready", int'(req_ready), 4'b0010);
    tick();
    req_valid = '0;
    drain();
    // rr_ptr now 2
    req_valid = 4'b1111;
    #1;
    check("ptr_after_1", int'(req_ready), 4'b0100);
    wait_grants(1);
    req_valid = '0;
    drain();

    // Reset mid-op on requester 1 (ptr would become 2)
    set_op(1, 5, 5);
    req_valid = 4'b0010;
    wait_grants(1);
    req_valid = '0;
    check("mid_busy", int'(busy), 1);
    cnt0 = rsp_count;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rsp_valid", int'(rsp_valid), 0);
    check("mid_busy_clr", int'(busy), 0);
    for (int i = 0; i < 10; i++) tick();
    check("mid_no_rsp", rsp_count, cnt0);
    check("mid_no_valid", int'(rsp_valid), 0);
    req_valid = 4'b1111;
    #1;
    check("mid_ptr0", int'(req_ready), 4'b0001);
    req_valid = '0;

    // Zero operand
    set_op(0, 0, 31);
    req_valid = 4'b0001;
    wait_grants(1);
    req_valid = '0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
